// File: rtl/core_wb_lsu_rsp_pkg.sv
// Shared LSU response types: trap causes, access sizes, slot states and slot metadata.
package core_wb_lsu_rsp_pkg;

    localparam logic [6:0] TRAP_LDACCESS = 7'd5;
    localparam logic [6:0] TRAP_STACCESS = 7'd7;

    // Widest offset (XLEN=64) and GPR index the metadata slot can hold.
    localparam int LSU_OFF_W = 3;
    localparam int LSU_RD_W  = 5;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'd0,
        LSU_SIZE_H = 2'd1,
        LSU_SIZE_W = 2'd2,
        LSU_SIZE_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_PEND  = 2'd1,
        SLOT_DONE  = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic                 load;
        lsu_size_e            size;
        logic                 sext;
        logic [LSU_OFF_W-1:0] offset;
        logic [LSU_RD_W-1:0]  rd;
    } lsu_meta_t;

endpackage

// File: rtl/core_wb_lsu_rsp_if.sv
// Request / response / writeback bundle between dmem, the response tracker and WB.
// master drives requests, dmem responses and wb_ready; slave is the tracker.
interface core_wb_lsu_rsp_if #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
);
    localparam int OW = $clog2(XLEN/8);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_load;
    logic [1:0]            req_size;
    logic                  req_sext;
    logic [OW-1:0]         req_offset;
    logic [REG_ADDR_W-1:0] req_rd;

    logic                  rsp_valid;
    logic                  rsp_err;
    logic [XLEN-1:0]       rsp_rdata;

    logic                  wb_valid;
    logic                  wb_ready;
    logic                  wb_rd_wen;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_wdata;
    logic                  wb_trap;
    logic [6:0]            wb_cause;

    modport master (
        output req_valid, req_load, req_size, req_sext, req_offset, req_rd,
        output rsp_valid, rsp_err, rsp_rdata,
        output wb_ready,
        input  req_ready,
        input  wb_valid, wb_rd_wen, wb_rd, wb_wdata, wb_trap, wb_cause
    );

    modport slave (
        input  req_valid, req_load, req_size, req_sext, req_offset, req_rd,
        input  rsp_valid, rsp_err, rsp_rdata,
        input  wb_ready,
        output req_ready,
        output wb_valid, wb_rd_wen, wb_rd, wb_wdata, wb_trap, wb_cause
    );

endinterface

// File: rtl/core_wb_lsu_rsp_align.sv
// Load data aligner: shift by byte offset, mask to access size, optional sign-extend.
// Latency: purely combinational.
// Backpressure: none.
module core_wb_lsu_rsp_align
    import core_wb_lsu_rsp_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]          data,
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  lsu_size_e                size,
    input  logic                     sext,
    output logic [XLEN-1:0]          result
);
    localparam logic [1:0] MAX_SIZE = (XLEN == 64) ? 2'd3 : 2'd2;

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] sign_bit;
    logic [6:0]      nbits;
    logic            neg;

    always_comb begin
        shifted  = data >> {offset, 3'b000};
        nbits    = 7'd8 << size;
        mask     = ~({XLEN{1'b1}} << nbits);
        sign_bit = {{(XLEN-1){1'b0}}, 1'b1} << (nbits - 7'd1);
        neg      = sext && (|(shifted & sign_bit));
        // Full-width accesses are always aligned, so the raw word is the result.
        if (size >= MAX_SIZE) begin
            result = data;
        end else begin
            result = (shifted & mask) | (neg ? ~mask : '0);
        end
    end

endmodule

// File: rtl/core_wb_lsu_rsp.sv
// In-order dmem response tracker feeding WB; DEPTH slots, load alignment, access-fault traps.
// Latency: rsp -> wb_valid next cycle; 0 cycles for a live PEND head when CORE_WB_RSP_BYPASS_EN is defined.
// Backpressure: req_ready drops when all slots are busy; dmem responses are never stalled.
module core_wb_lsu_rsp
    import core_wb_lsu_rsp_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int DEPTH      = 2,
    parameter int REG_ADDR_W = 5
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             flush,
    core_wb_lsu_rsp_if.slave bus,
    output logic             rsp_unexpected
);
    localparam int OW = $clog2(XLEN/8);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    slot_state_e     st_q   [DEPTH];
    slot_state_e     st_d   [DEPTH];
    logic            kill_q [DEPTH];
    logic            kill_d [DEPTH];
    lsu_meta_t       meta_q [DEPTH];
    lsu_meta_t       meta_d [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];
    logic            err_q  [DEPTH];
    logic            err_d  [DEPTH];

    logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0] rsp_ptr_q,   rsp_ptr_d;
    logic [PW-1:0] head_ptr_q,  head_ptr_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [CW-1:0] pend_q,      pend_d;
    logic          unexp_q,     unexp_d;

    logic            req_rdy;
    logic            alloc;
    logic            rsp_take;
    logic            head_live_done;
    logic            bypass_hit;
    logic            wb_vld;
    logic            pop;
    lsu_meta_t       head_meta;
    lsu_meta_t       new_meta;
    logic            sel_err;
    logic [XLEN-1:0] sel_data;
    logic [XLEN-1:0] aligned;
    logic [REG_ADDR_W-1:0] head_rd;
    logic            load_ok;

    // Occupancy comes from registered state only; a same-cycle pop does not open a slot.
    assign req_rdy   = (cnt_q != CW'(DEPTH));
    assign alloc     = bus.req_valid && req_rdy;
    assign rsp_take  = bus.rsp_valid && (pend_q != '0);
    assign head_meta = meta_q[head_ptr_q];
    assign head_rd   = REG_ADDR_W'(head_meta.rd);

    assign head_live_done = (st_q[head_ptr_q] == SLOT_DONE) && !kill_q[head_ptr_q];

`ifdef CORE_WB_RSP_BYPASS_EN
    // A live PEND head is always the oldest PEND slot, so this response is its own.
    assign bypass_hit = (st_q[head_ptr_q] == SLOT_PEND) && !kill_q[head_ptr_q] && bus.rsp_valid;
    assign sel_data   = bypass_hit ? bus.rsp_rdata : data_q[head_ptr_q];
    assign sel_err    = bypass_hit ? bus.rsp_err   : err_q[head_ptr_q];
`else
    assign bypass_hit = 1'b0;
    assign sel_data   = data_q[head_ptr_q];
    assign sel_err    = err_q[head_ptr_q];
`endif

    assign wb_vld = head_live_done || bypass_hit;
    assign pop    = ((st_q[head_ptr_q] == SLOT_DONE) && kill_q[head_ptr_q])
                 || (wb_vld && bus.wb_ready);

    always_comb begin
        new_meta        = '0;
        new_meta.load   = bus.req_load;
        new_meta.size   = lsu_size_e'(bus.req_size);
        new_meta.sext   = bus.req_sext;
        new_meta.offset = LSU_OFF_W'(bus.req_offset);
        new_meta.rd     = LSU_RD_W'(bus.req_rd);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            st_d[i]   = st_q[i];
            kill_d[i] = kill_q[i];
            meta_d[i] = meta_q[i];
            data_d[i] = data_q[i];
            err_d[i]  = err_q[i];
        end
        alloc_ptr_d = alloc_ptr_q;
        rsp_ptr_d   = rsp_ptr_q;
        head_ptr_d  = head_ptr_q;
        unexp_d     = unexp_q || (bus.rsp_valid && !rsp_take);

        if (rsp_take) begin
            st_d[rsp_ptr_q]   = SLOT_DONE;
            data_d[rsp_ptr_q] = bus.rsp_rdata;
            err_d[rsp_ptr_q]  = bus.rsp_err;
            rsp_ptr_d         = rsp_ptr_q + 1'b1;
        end
        if (pop) begin
            st_d[head_ptr_q] = SLOT_EMPTY;
            head_ptr_d       = head_ptr_q + 1'b1;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (st_q[i] != SLOT_EMPTY) begin
                    kill_d[i] = 1'b1;
                end
            end
        end
        // Applied after the flush so a request issued on the new path survives it.
        if (alloc) begin
            st_d[alloc_ptr_q]   = SLOT_PEND;
            kill_d[alloc_ptr_q] = 1'b0;
            meta_d[alloc_ptr_q] = new_meta;
            err_d[alloc_ptr_q]  = 1'b0;
            alloc_ptr_d         = alloc_ptr_q + 1'b1;
        end

        cnt_d  = cnt_q  + CW'(alloc) - CW'(pop);
        pend_d = pend_q + CW'(alloc) - CW'(rsp_take);
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]   <= SLOT_EMPTY;
                kill_q[i] <= 1'b0;
                meta_q[i] <= '0;
                data_q[i] <= '0;
                err_q[i]  <= 1'b0;
            end
            alloc_ptr_q <= '0;
            rsp_ptr_q   <= '0;
            head_ptr_q  <= '0;
            cnt_q       <= '0;
            pend_q      <= '0;
            unexp_q     <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]   <= st_d[i];
                kill_q[i] <= kill_d[i];
                meta_q[i] <= meta_d[i];
                data_q[i] <= data_d[i];
                err_q[i]  <= err_d[i];
            end
            alloc_ptr_q <= alloc_ptr_d;
            rsp_ptr_q   <= rsp_ptr_d;
            head_ptr_q  <= head_ptr_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            unexp_q     <= unexp_d;
        end
    end

    core_wb_lsu_rsp_align #(
        .XLEN (XLEN)
    ) u_align (
        .data   (sel_data),
        .offset (OW'(head_meta.offset)),
        .size   (head_meta.size),
        .sext   (head_meta.sext),
        .result (aligned)
    );

    assign load_ok = wb_vld && head_meta.load && !sel_err;

    assign bus.req_ready = req_rdy;
    assign bus.wb_valid  = wb_vld;
    assign bus.wb_rd     = wb_vld ? head_rd : '0;
    assign bus.wb_rd_wen = load_ok && (head_rd != '0);
    assign bus.wb_wdata  = load_ok ? aligned : '0;
    assign bus.wb_trap   = wb_vld && sel_err;
    assign bus.wb_cause  = (wb_vld && sel_err)
                         ? (head_meta.load ? TRAP_LDACCESS : TRAP_STACCESS) : 7'd0;
    assign rsp_unexpected = unexp_q;

endmodule
